// File: rtl/axi_4k_read_scheduler.sv
// rtl/axi_4k_read_scheduler.sv - AXI4 INCR read-burst scheduler with 4 KB splitting and outstanding tracking
module axi_4k_read_scheduler #(
    parameter int ADDR_WIDTH      = 32,
    parameter int LEN_WIDTH       = 24,
    parameter int MAX_BURST_BEATS = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_bytes,
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [7:0]            M_AXI_ARLEN,
    output logic [2:0]            M_AXI_ARSIZE,
    output logic [1:0]            M_AXI_ARBURST,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic                  M_AXI_RVALID,
    input  logic                  M_AXI_RREADY,
    input  logic                  M_AXI_RLAST,
    input  logic [1:0]            M_AXI_RRESP,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int BEAT_W = LEN_WIDTH - 2;
    localparam int CMP_W  = (BEAT_W > 11) ? BEAT_W : 11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_ADDR,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [BEAT_W-1:0]     beats_rem_q;
    logic [BEAT_W-1:0]     rem_after;
    logic [8:0]            burst_beats_q;
    logic [8:0]            calc_beats;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [7:0]            arlen_q;
    logic [3:0]            outstanding_q;
    logic [3:0]            outstanding_next;
    logic                  err_q;

    logic                  cmd_hs;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  rlast_hs;
    logic                  calc_go;
    logic [10:0]           page_beats;
    logic [CMP_W-1:0]      rem_ext;
    logic [CMP_W-1:0]      page_ext;
    logic [CMP_W-1:0]      cap_ext;
    logic [CMP_W-1:0]      pick;
    logic                  unused_low_bits;

    assign unused_low_bits = ^{cmd_addr[1:0], cmd_bytes[1:0]};

    assign cmd_hs = (state == S_IDLE) && cmd_valid;
    assign ar_hs  = (state == S_ADDR) && M_AXI_ARREADY;
    assign r_hs   = M_AXI_RVALID && M_AXI_RREADY;
    // Beats seen with nothing outstanding (e.g. stragglers after a reset) are ignored.
    assign rlast_hs = r_hs && M_AXI_RLAST && (outstanding_q != 4'd0);
    assign calc_go  = outstanding_q < 4'(MAX_OUTSTANDING);

    // Beats left before the next 4 KB page; addr_q is always word aligned.
    assign page_beats = 11'd1024 - {1'b0, addr_q[11:2]};
    assign rem_after  = beats_rem_q - BEAT_W'(burst_beats_q);

    always_comb begin
        rem_ext  = CMP_W'(beats_rem_q);
        page_ext = CMP_W'(page_beats);
        cap_ext  = CMP_W'(MAX_BURST_BEATS);
        pick     = rem_ext;
        if (page_ext < pick) pick = page_ext;
        if (cap_ext < pick)  pick = cap_ext;
        calc_beats = 9'(pick);
    end

    always_comb begin
        outstanding_next = outstanding_q;
        case ({ar_hs, rlast_hs})
            2'b10:   outstanding_next = outstanding_q + 4'd1;
            2'b01:   outstanding_next = outstanding_q - 4'd1;
            default: outstanding_next = outstanding_q;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_next = (cmd_bytes[LEN_WIDTH-1:2] == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (calc_go) state_next = S_ADDR;
            end
            S_ADDR: begin
                if (ar_hs) state_next = (rem_after != '0) ? S_CALC : S_DRAIN;
            end
            // Leave as soon as the last RLAST lands so done follows it by one cycle.
            S_DRAIN: begin
                if (outstanding_next == 4'd0) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            addr_q        <= '0;
            beats_rem_q   <= '0;
            burst_beats_q <= '0;
            araddr_q      <= '0;
            arlen_q       <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            outstanding_q <= outstanding_next;
            if (cmd_hs) begin
                addr_q      <= {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
                beats_rem_q <= cmd_bytes[LEN_WIDTH-1:2];
                err_q       <= 1'b0;
            end else if (r_hs && (M_AXI_RRESP != 2'b00) && (outstanding_q != 4'd0)) begin
                err_q <= 1'b1;
            end
            if (state == S_CALC) begin
                araddr_q      <= addr_q;
                arlen_q       <= 8'(calc_beats - 9'd1);
                burst_beats_q <= calc_beats;
            end
            if (ar_hs) begin
                addr_q      <= addr_q + ADDR_WIDTH'({burst_beats_q, 2'b00});
                beats_rem_q <= rem_after;
            end
        end
    end

    assign cmd_ready     = (state == S_IDLE);
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);
    assign err           = err_q;
    assign M_AXI_ARVALID = (state == S_ADDR);
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARLEN   = arlen_q;
    assign M_AXI_ARSIZE  = 3'b010;
    assign M_AXI_ARBURST = 2'b01;
endmodule
